// File: rtl/axi_lite_data_memory_if.sv
// AXI-lite bus bundle between the data-memory responder and its requester.
// The slave modport is the memory side; the master modport is the requester side.
interface axi_lite_data_memory_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
);
  logic              s_awvalid;
  logic              s_awready;
  logic [ADDR_W-1:0] s_awaddr;
  logic              s_wvalid;
  logic              s_wready;
  logic [DATA_W-1:0] s_wdata;
  logic [STRB_W-1:0] s_wstrb;
  logic              s_bvalid;
  logic              s_bready;
  logic [1:0]        s_bresp;
  logic              s_arvalid;
  logic              s_arready;
  logic [ADDR_W-1:0] s_araddr;
  logic              s_rvalid;
  logic              s_rready;
  logic [DATA_W-1:0] s_rdata;
  logic [1:0]        s_rresp;

  modport slave (
    input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
    input  s_arvalid, s_araddr, s_rready,
    output s_awready, s_wready, s_bvalid, s_bresp,
    output s_arready, s_rvalid, s_rdata, s_rresp
  );

  modport master (
    output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
    output s_arvalid, s_araddr, s_rready,
    input  s_awready, s_wready, s_bvalid, s_bresp,
    input  s_arready, s_rvalid, s_rdata, s_rresp
  );
endinterface

// File: rtl/axi_lite_data_memory.sv
// AXI-lite responder backed by a word-organised synchronous RAM with byte strobes.
// Independent read and write channels, one outstanding transaction per direction.
module axi_lite_data_memory #(
  parameter int XLEN      = 32,
  parameter int DMADDRLEN = XLEN,
  parameter int DMDATALEN = XLEN,
  parameter int DMSTRBLEN = DMDATALEN / 8,
  parameter int DEPTH     = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  axi_lite_data_memory_if.slave  s
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  if (DMDATALEN != XLEN) begin : g_bad_datalen
    $fatal(1, "axi_lite_data_memory: DMDATALEN must equal XLEN");
  end
  if ((1 << IDX_W) != DEPTH) begin : g_bad_depth
    $fatal(1, "axi_lite_data_memory: DEPTH must be a power of two");
  end

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;

  function automatic logic in_range(input logic [DMADDRLEN-1:0] addr);
    return (addr >> (IDX_W + 2)) == '0;
  endfunction

  logic [DMDATALEN-1:0] mem [DEPTH];

  w_state_e             w_state_q, w_state_d;
  logic                 awready_q, wready_q, bvalid_q;
  logic [1:0]           bresp_q;
  logic [DMADDRLEN-1:0] awaddr_q;
  logic [DMDATALEN-1:0] wdata_q;
  logic [DMSTRBLEN-1:0] wstrb_q;

  r_state_e             r_state_q, r_state_d;
  logic                 arready_q, rvalid_q;
  logic [1:0]           rresp_q;
  logic [DMDATALEN-1:0] rdata_q;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, commit, wr_ok, rd_ok;
  logic [DMADDRLEN-1:0] wr_addr;
  logic [DMDATALEN-1:0] wr_data;
  logic [DMSTRBLEN-1:0] wr_strb;

  assign aw_hs = s.s_awvalid && awready_q;
  assign w_hs  = s.s_wvalid  && wready_q;
  assign b_hs  = bvalid_q    && s.s_bready;
  assign ar_hs = s.s_arvalid && arready_q;
  assign r_hs  = rvalid_q    && s.s_rready;

  // A handshake on the commit edge itself has not been captured yet, so take it live.
  assign wr_addr = aw_hs ? s.s_awaddr : awaddr_q;
  assign wr_data = w_hs  ? s.s_wdata  : wdata_q;
  assign wr_strb = w_hs  ? s.s_wstrb  : wstrb_q;
  assign wr_ok   = in_range(wr_addr);
  assign rd_ok   = in_range(s.s_araddr);
  assign commit  = !rst && (w_state_d == W_RESP) && (w_state_q != W_RESP);

  // NOTE: every combinational output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) w_state_d = W_RESP;
        else if (aw_hs)    w_state_d = W_HAVE_A;
        else if (w_hs)     w_state_d = W_HAVE_D;
      end
      W_HAVE_A: if (w_hs)  w_state_d = W_RESP;
      W_HAVE_D: if (aw_hs) w_state_d = W_RESP;
      W_RESP:   if (b_hs)  w_state_d = W_IDLE;
      default:             w_state_d = W_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= (w_state_d == W_IDLE) || (w_state_d == W_HAVE_D);
      wready_q  <= (w_state_d == W_IDLE) || (w_state_d == W_HAVE_A);
      bvalid_q  <= (w_state_d == W_RESP);
      if (aw_hs) awaddr_q <= s.s_awaddr;
      if (w_hs) begin
        wdata_q <= s.s_wdata;
        wstrb_q <= s.s_wstrb;
      end
      if (commit) bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // NOTE: the RAM array is deliberately not reset; only the control and response registers are.
  always_ff @(posedge clk) begin
    if (commit && wr_ok) begin
      for (int b = 0; b < DMSTRBLEN; b++) begin
        if (wr_strb[b]) mem[wr_addr[IDX_W+1:2]][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_RESP;
      R_RESP:  if (r_hs)  r_state_d = R_IDLE;
      default:            r_state_d = R_IDLE;
    endcase
  end

  // The RAM read samples the array before any same-edge write lands: read-before-write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= (r_state_d == R_IDLE);
      rvalid_q  <= (r_state_d == R_RESP);
      if (ar_hs) begin
        rdata_q <= rd_ok ? mem[s.s_araddr[IDX_W+1:2]] : '0;
        rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign s.s_awready = awready_q;
  assign s.s_wready  = wready_q;
  assign s.s_bvalid  = bvalid_q;
  assign s.s_bresp   = bresp_q;
  assign s.s_arready = arready_q;
  assign s.s_rvalid  = rvalid_q;
  assign s.s_rdata   = rdata_q;
  assign s.s_rresp   = rresp_q;
endmodule

// File: tb/tb_axi_lite_data_memory.sv
// Bench for axi_lite_data_memory: directed AXI-lite traffic, a transaction-level
// memory model with response queues, and literal expectations for each scenario.
module tb_axi_lite_data_memory;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_lite_data_memory_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi_lite_data_memory #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Transaction-level model: words by index, pending address/data halves, expected responses.
  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    bit          care;
  } rexp_t;

  logic [31:0] mem_m [int];
  logic [31:0] aw_q [$];
  logic [31:0] wd_q [$];
  logic [3:0]  ws_q [$];
  logic [1:0]  bq [$];
  rexp_t       rq [$];
  logic        rst_seen = 1'b1;

  function automatic void model_read(input logic [31:0] addr);
    rexp_t e;
    int    idx = int'(addr >> 2);
    if (addr >= 32'(DEPTH * 4)) begin
      e.data = 32'h0; e.resp = 2'b10; e.care = 1'b1;
    end else if (mem_m.exists(idx)) begin
      e.data = mem_m[idx]; e.resp = 2'b00; e.care = 1'b1;
    end else begin
      e.data = 32'h0; e.resp = 2'b00; e.care = 1'b0;
    end
    rq.push_back(e);
  endfunction

  function automatic void model_commit(input logic [31:0] addr, input logic [31:0] data,
                                       input logic [3:0] strb);
    int          idx = int'(addr >> 2);
    logic [31:0] w;
    if (addr >= 32'(DEPTH * 4)) begin
      bq.push_back(2'b10);
      return;
    end
    if (strb != 4'h0) begin
      if (mem_m.exists(idx) || strb == 4'hF) begin
        w = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
        for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
        mem_m[idx] = w;
      end else begin
        mem_m.delete(idx);
      end
    end
    bq.push_back(2'b00);
  endfunction

  always @(posedge clk) begin
    rst_seen <= rst;
    if (rst) begin
      aw_q.delete(); wd_q.delete(); ws_q.delete(); bq.delete(); rq.delete();
    end else begin
      if (bus.s_bvalid && bus.s_bready && bq.size() > 0) void'(bq.pop_front());
      if (bus.s_rvalid && bus.s_rready && rq.size() > 0) void'(rq.pop_front());
      if (bus.s_arvalid && bus.s_arready) model_read(bus.s_araddr);
      if (bus.s_awvalid && bus.s_awready) aw_q.push_back(bus.s_awaddr);
      if (bus.s_wvalid && bus.s_wready) begin
        wd_q.push_back(bus.s_wdata);
        ws_q.push_back(bus.s_wstrb);
      end
      if (aw_q.size() > 0 && wd_q.size() > 0)
        model_commit(aw_q.pop_front(), wd_q.pop_front(), ws_q.pop_front());
    end
  end

  // Compare process: mid-cycle, outputs against the model's expectations.
  always @(negedge clk) begin
    if (rst_seen) begin
      check("reset ctrl outputs",
            {23'b0, bus.s_awready, bus.s_wready, bus.s_arready, bus.s_bvalid,
             bus.s_bresp, bus.s_rvalid, bus.s_rresp}, 32'h0);
      check("reset rdata", bus.s_rdata, 32'h0);
    end else begin
      check("bvalid vs model", {31'b0, bus.s_bvalid}, {31'b0, bq.size() > 0});
      if (bus.s_bvalid && bq.size() > 0) check("bresp vs model", {30'b0, bus.s_bresp}, {30'b0, bq[0]});
      check("rvalid vs model", {31'b0, bus.s_rvalid}, {31'b0, rq.size() > 0});
      if (bus.s_rvalid && rq.size() > 0) begin
        check("rresp vs model", {30'b0, bus.s_rresp}, {30'b0, rq[0].resp});
        if (rq[0].care) check("rdata vs model", bus.s_rdata, rq[0].data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output int lat);
    int n = 0;
    bit aw_done = 1'b0;
    bit w_done = 1'b0;
    bus.s_awaddr = addr; bus.s_wdata = data; bus.s_wstrb = strb;
    bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      @(posedge clk);
      if (bus.s_awvalid && bus.s_awready) aw_done = 1'b1;
      if (bus.s_wvalid && bus.s_wready) w_done = 1'b1;
      #1;
      if (aw_done) bus.s_awvalid = 1'b0;
      if (w_done) bus.s_wvalid = 1'b0;
      n++;
    end
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    check("write handshake timeout", {31'b0, aw_done && w_done}, 32'h1);
    lat = 0;
    while (!bus.s_bvalid && lat < 20) begin step(); lat++; end
    resp = bus.s_bresp;
    bus.s_bready = 1'b1;
    step();
    bus.s_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    int n = 0;
    bit done = 1'b0;
    bus.s_araddr = addr; bus.s_arvalid = 1'b1;
    while (!done && n < 20) begin
      @(posedge clk);
      if (bus.s_arvalid && bus.s_arready) done = 1'b1;
      #1;
      if (done) bus.s_arvalid = 1'b0;
      n++;
    end
    bus.s_arvalid = 1'b0;
    check("read handshake timeout", {31'b0, done}, 32'h1);
    lat = 0;
    while (!bus.s_rvalid && lat < 20) begin step(); lat++; end
    data = bus.s_rdata;
    resp = bus.s_rresp;
    bus.s_rready = 1'b1;
    step();
    bus.s_rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  resp;
    int          lat;
    logic        hs_ok;

    bus.s_awvalid = 1'b0; bus.s_awaddr = '0; bus.s_wvalid = 1'b0; bus.s_wdata = '0;
    bus.s_wstrb = '0; bus.s_bready = 1'b0; bus.s_arvalid = 1'b0; bus.s_araddr = '0;
    bus.s_rready = 1'b0;

    // Reset release
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("readies before first clean edge", {29'b0, bus.s_awready, bus.s_wready, bus.s_arready}, 32'h0);
    step();
    check("readies after reset", {29'b0, bus.s_awready, bus.s_wready, bus.s_arready}, 32'h7);

    // Full write then read
    axi_write(32'h10, 32'hDEADBEEF, 4'hF, resp, lat);
    check("wr 0x10 bresp", {30'b0, resp}, 32'h0);
    check("wr 0x10 bvalid latency", lat, 0);
    axi_read(32'h10, rd, resp, lat);
    check("rd 0x10 data", rd, 32'hDEADBEEF);
    check("rd 0x10 rresp", {30'b0, resp}, 32'h0);
    check("rd 0x10 rvalid latency", lat, 0);

    // Byte strobes
    axi_write(32'h20, 32'h11223344, 4'hF, resp, lat);
    axi_write(32'h20, 32'hAABBCCDD, 4'b0101, resp, lat);
    axi_read(32'h20, rd, resp, lat);
    check("strobe 0101 merge", rd, 32'h11BB33DD);
    axi_write(32'h20, 32'hFFFFFFFF, 4'b0000, resp, lat);
    check("wstrb=0 bresp", {30'b0, resp}, 32'h0);
    axi_read(32'h20, rd, resp, lat);
    check("wstrb=0 leaves word", rd, 32'h11BB33DD);

    // Channel ordering: W first, AW three cycles later, slow bready
    bus.s_wdata = 32'h0BADF00D; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
    @(posedge clk);
    hs_ok = bus.s_wready;
    #1;
    bus.s_wvalid = 1'b0;
    check("W-only handshake", {31'b0, hs_ok}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      check("W_HAVE_D wready low", {31'b0, bus.s_wready}, 32'h0);
      check("W_HAVE_D awready high", {31'b0, bus.s_awready}, 32'h1);
      if (i < 2) step();
    end
    bus.s_awaddr = 32'h4; bus.s_awvalid = 1'b1;
    step();
    bus.s_awvalid = 1'b0;
    check("late AW bvalid", {31'b0, bus.s_bvalid}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("bvalid held", {31'b0, bus.s_bvalid}, 32'h1);
      check("bresp held", {30'b0, bus.s_bresp}, 32'h0);
      check("awready low in W_RESP", {31'b0, bus.s_awready}, 32'h0);
      check("wready low in W_RESP", {31'b0, bus.s_wready}, 32'h0);
    end
    bus.s_bready = 1'b1;
    step();
    bus.s_bready = 1'b0;
    check("readies back after B", {30'b0, bus.s_awready, bus.s_wready}, 32'h3);
    axi_read(32'h4, rd, resp, lat);
    check("rd 0x4 data", rd, 32'h0BADF00D);

    // Range errors
    axi_write(32'h0, 32'h01020304, 4'hF, resp, lat);
    axi_write(32'h1000, 32'h99999999, 4'hF, resp, lat);
    check("OOR write bresp", {30'b0, resp}, 32'h2);
    axi_read(32'h0, rd, resp, lat);
    check("OOR write left word 0", rd, 32'h01020304);
    axi_read(32'h1000, rd, resp, lat);
    check("OOR read rdata", rd, 32'h0);
    check("OOR read rresp", {30'b0, resp}, 32'h2);
    axi_write(32'hFFC, 32'h7E57AB1E, 4'hF, resp, lat);
    check("wr 0xFFC bresp", {30'b0, resp}, 32'h0);
    axi_read(32'hFFC, rd, resp, lat);
    check("rd 0xFFC rresp", {30'b0, resp}, 32'h0);
    check("rd 0xFFC data", rd, 32'h7E57AB1E);

    // Read/write collision on the commit edge
    axi_write(32'h8, 32'h12345678, 4'hF, resp, lat);
    bus.s_awaddr = 32'h8; bus.s_wdata = 32'h00000055; bus.s_wstrb = 4'hF;
    bus.s_araddr = 32'h8;
    bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1; bus.s_arvalid = 1'b1;
    @(posedge clk);
    hs_ok = bus.s_awready && bus.s_wready && bus.s_arready;
    #1;
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
    check("collision handshakes", {31'b0, hs_ok}, 32'h1);
    check("collision rvalid", {31'b0, bus.s_rvalid}, 32'h1);
    check("collision old data", bus.s_rdata, 32'h12345678);
    check("collision bvalid", {31'b0, bus.s_bvalid}, 32'h1);
    bus.s_bready = 1'b1; bus.s_rready = 1'b1;
    step();
    bus.s_bready = 1'b0; bus.s_rready = 1'b0;
    axi_read(32'h8, rd, resp, lat);
    check("after collision new data", rd, 32'h00000055);

    // Reset while holding only the write address
    axi_write(32'h30, 32'hCAFEF00D, 4'hF, resp, lat);
    bus.s_awaddr = 32'h30; bus.s_awvalid = 1'b1;
    step();
    bus.s_awvalid = 1'b0;
    check("W_HAVE_A awready low", {31'b0, bus.s_awready}, 32'h0);
    check("W_HAVE_A wready high", {31'b0, bus.s_wready}, 32'h1);
    bus.s_wdata = 32'hFFFFFFFF; bus.s_wstrb = 4'hF;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
    check("post-reset readies", {29'b0, bus.s_awready, bus.s_wready, bus.s_arready}, 32'h7);
    check("post-reset bvalid", {31'b0, bus.s_bvalid}, 32'h0);
    axi_read(32'h30, rd, resp, lat);
    check("reset dropped write", rd, 32'hCAFEF00D);

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
